// File: rtl/eep_mem_wbuf_pkg.sv
// eep_mem_wbuf_pkg: shared types for the EEPROM byte-to-word SRAM port.
package eep_mem_wbuf_pkg;
    localparam int EEP_MEM_WAIT_DEF = 3;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } ewr_ent_t;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_ACC, WR_REQ, WR_ACC, HOLD} state_t;
endpackage

// File: rtl/eep_mem_wbuf_wfifo.sv
// eep_wfifo: circular posted-write FIFO with newest-entry address match lookup.
module eep_wfifo
    import eep_mem_wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  ewr_ent_t    ent_i,
    input  logic [15:0] look_addr_i,
    output ewr_ent_t    head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic        hit_o,
    output logic [7:0]  hit_data_o
);
    localparam int AW = $clog2(DEPTH);
    ewr_ent_t      mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic [AW-1:0] wr_idx;
    assign wr_idx  = rd_q + cnt_q[AW-1:0];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_q + AW'(pop_i);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_idx] <= ent_i;
    end
    // Walk oldest to newest so the newest matching entry wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < cnt_q && mem_q[rd_q + AW'(i)].addr == look_addr_i) begin
                hit_o      = 1'b1;
                hit_data_o = mem_q[rd_q + AW'(i)].data;
            end
        end
    end
endmodule

// File: rtl/eep_mem_wbuf.sv
// eep_mem_wbuf: posted-write byte-to-word port from the 24Cxx core to the 16-bit save SRAM.
// Optional EEP_MEM_DIRTY_EN adds a sticky dirty flag set by every completed SRAM write.
module eep_mem_wbuf
    import eep_mem_wbuf_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int          MEM_WAIT   = EEP_MEM_WAIT_DEF,
    parameter logic [18:0] BASE_ADDR  = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_di_i,
    input  logic        req_we_i,
    input  logic        req_oe_i,
    output logic [7:0]  rd_do_o,
    output logic        rd_vld_o,
    output logic        busy_o,
    output logic        ovf_o,
    input  logic        mem_gnt_i,
    input  logic [15:0] mem_do_i,
    output logic [15:0] mem_di_o,
    output logic [18:0] mem_addr_o,
    output logic        mem_ce_o,
    output logic        mem_oe_o,
    output logic        mem_we_lo_o,
    output logic        mem_we_hi_o,
    output logic        dirty_o,
    input  logic        dirty_clr_i
);
    localparam int WW = $clog2(MEM_WAIT + 1);
    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          rd_pend_q, rd_vld_q, ovf_q;
    logic [15:0]   rd_addr_q;
    logic [7:0]    rd_do_q, fifo_data, fwd_data;
    ewr_ent_t      head;
    logic          full, empty, fifo_hit, push, pop, acc, last, new_rd, fwd, new_miss, rd_done;
    logic          rd_sel, wr_sel;
    assign acc      = state_q == RD_ACC || state_q == WR_ACC;
    assign last     = acc && wait_q == WW'(MEM_WAIT - 1);
    assign pop      = last && state_q == WR_ACC;
    assign rd_done  = last && state_q == RD_ACC;
    assign push     = req_we_i && (!full || pop);
    assign new_rd   = req_oe_i && !rd_pend_q;
    // A same-cycle write shares req_addr, so an accepted push always satisfies the read.
    assign fwd      = new_rd && (push || fifo_hit);
    assign fwd_data = push ? req_di_i : fifo_data;
    assign new_miss = new_rd && !fwd;
    eep_wfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (pop),
        .ent_i      ('{addr: req_addr_i, data: req_di_i}),
        .look_addr_i(req_addr_i),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .hit_o      (fifo_hit),
        .hit_data_o (fifo_data)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:           state_d = (rd_pend_q || new_miss) ? RD_REQ : !empty ? WR_REQ : IDLE;
            RD_REQ:         state_d = mem_gnt_i ? RD_ACC : RD_REQ;
            WR_REQ:         state_d = mem_gnt_i ? WR_ACC : WR_REQ;
            RD_ACC, WR_ACC: state_d = last ? HOLD : state_q;
            default:        state_d = IDLE;
        endcase
    end
    assign wait_d = (acc && !last) ? wait_q + 1'b1 : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            ovf_q     <= 1'b0;
            rd_addr_q <= '0;
            rd_do_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rd_pend_q <= new_miss || (rd_pend_q && !rd_done);
            rd_vld_q  <= fwd || rd_done;
            ovf_q     <= ovf_q || (req_we_i && !push);
            rd_addr_q <= new_miss ? req_addr_i : rd_addr_q;
            rd_do_q   <= fwd ? fwd_data : rd_done ? (rd_addr_q[0] ? mem_do_i[7:0] : mem_do_i[15:8]) : rd_do_q;
        end
    end
`ifdef EEP_MEM_DIRTY_EN
    logic dirty_q;
    // A completion wins over a same-cycle clear so no update is lost.
    always_ff @(posedge clk) begin
        if (rst) dirty_q <= 1'b0;
        else     dirty_q <= pop || (dirty_q && !dirty_clr_i);
    end
    assign dirty_o = dirty_q;
`else
    logic unused_dirty_clr;
    assign unused_dirty_clr = dirty_clr_i;
    assign dirty_o          = 1'b0;
`endif
    assign rd_sel      = state_q == RD_REQ || state_q == RD_ACC;
    assign wr_sel      = state_q == WR_REQ || state_q == WR_ACC;
    assign mem_addr_o  = rd_sel ? (BASE_ADDR | {4'b0, rd_addr_q[15:1]}) :
                         wr_sel ? (BASE_ADDR | {4'b0, head.addr[15:1]}) : '0;
    assign mem_di_o    = wr_sel ? {head.data, head.data} : '0;
    assign mem_ce_o    = state_q != IDLE;
    assign mem_oe_o    = state_q == RD_ACC;
    assign mem_we_hi_o = state_q == WR_ACC && !head.addr[0];
    assign mem_we_lo_o = state_q == WR_ACC && head.addr[0];
    assign busy_o      = full || rd_pend_q;
    assign rd_do_o     = rd_do_q;
    assign rd_vld_o    = rd_vld_q;
    assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_eep_mem_wbuf.sv
// tb_eep_mem_wbuf: byte-level memory/queue model checked every cycle plus directed literal checks.
module tb_eep_mem_wbuf;
    localparam int DEPTH = 4;
    localparam int MW    = 3;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_addr;
    logic [7:0]  req_di;
    logic        req_we, req_oe, gnt, dirty_clr;
    logic [7:0]  rd_do;
    logic        rd_vld, busy, ovf, mem_ce, mem_oe, we_lo, we_hi, dirty;
    logic [15:0] mem_do, mem_di;
    logic [18:0] mem_addr;

    eep_mem_wbuf #(.FIFO_DEPTH(DEPTH), .MEM_WAIT(MW), .BASE_ADDR(19'h0)) dut (
        .clk(clk), .rst(rst), .req_addr_i(req_addr), .req_di_i(req_di), .req_we_i(req_we),
        .req_oe_i(req_oe), .rd_do_o(rd_do), .rd_vld_o(rd_vld), .busy_o(busy), .ovf_o(ovf),
        .mem_gnt_i(gnt), .mem_do_i(mem_do), .mem_di_o(mem_di), .mem_addr_o(mem_addr),
        .mem_ce_o(mem_ce), .mem_oe_o(mem_oe), .mem_we_lo_o(we_lo), .mem_we_hi_o(we_hi),
        .dirty_o(dirty), .dirty_clr_i(dirty_clr)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc++;

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", n, a, e, cyc);
        end
    endfunction

    typedef struct {logic [15:0] a; logic [7:0] d;} went_t;
    typedef struct {logic [7:0] d; bit fwd; int cyc;} rexp_t;
    went_t       q[$];
    rexp_t       eq[$];
    logic [7:0]  env[65536];
    logic [7:0]  mdl[65536];
    bit          loaded = 0, read_out, ovf_exp, dirty_exp, pop_now, hit;
    logic [15:0] read_addr;
    logic [7:0]  hd;
    int          scnt, we_cnt = 0, hi_cnt = 0, oe_cnt = 0, wdone = 0, busy_cnt = 0, last_vld_cyc = 0;
    logic [18:0] last_we_addr = '0;
    logic [15:0] last_we_di = '0;
    logic [7:0]  last_rd_do = '0;
    rexp_t       re;
    went_t       f;

    assign mem_do = {env[{mem_addr[14:0], 1'b0}], env[{mem_addr[14:0], 1'b1}]};

    // SRAM environment and reference model share one sampling point in the middle of each cycle.
    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 65536; i++) begin
                env[i] = 8'(i) ^ 8'h3C;
                mdl[i] = 8'(i) ^ 8'h3C;
            end
            env[4] = 8'hA1; env[5] = 8'hB2; mdl[4] = 8'hA1; mdl[5] = 8'hB2;
            loaded = 1;
        end
        if (rst) begin
            q.delete(); eq.delete();
            read_out = 0; ovf_exp = 0; dirty_exp = 0; scnt = 0;
        end else begin
            pop_now = 0;
            if (rd_vld) begin
                last_vld_cyc = cyc; last_rd_do = rd_do;
                chk("rd_expected", eq.size() != 0, 1);
                if (eq.size() != 0) begin
                    re = eq.pop_front();
                    chk("rd_do", rd_do, re.d);
                    if (re.fwd) chk("rd_fwd_latency", cyc - re.cyc, 1);
                    else read_out = 0;
                end
            end
            if (busy) busy_cnt++;
            chk("busy", busy, (q.size() == DEPTH) || read_out);
            chk("ovf", ovf, ovf_exp);
            chk("dirty", dirty, dirty_exp);
            if (mem_oe) begin
                oe_cnt++;
                chk("oe_pending", read_out, 1);
                chk("oe_addr", mem_addr, {4'b0, read_addr[15:1]});
                chk("oe_ce", mem_ce, 1);
            end
            if (we_hi || we_lo) begin
                we_cnt++; last_we_addr = mem_addr; last_we_di = mem_di;
                if (we_hi) begin hi_cnt++; env[{mem_addr[14:0], 1'b0}] = mem_di[15:8]; end
                if (we_lo) env[{mem_addr[14:0], 1'b1}] = mem_di[7:0];
                chk("we_queued", q.size() != 0, 1);
                chk("we_ce", mem_ce, 1);
                if (q.size() != 0) begin
                    f = q[0];
                    chk("we_addr", mem_addr, {4'b0, f.a[15:1]});
                    chk("we_di", mem_di, {f.d, f.d});
                    chk("we_lane", {we_hi, we_lo}, {~f.a[0], f.a[0]});
                    scnt++;
                    pop_now = scnt == MW;
                end
            end else if (scnt != 0) begin
                chk("we_len", scnt, MW);
                scnt = 0;
            end
            if (req_oe && !read_out) begin
                hit = 0; hd = '0;
                if (req_we && (q.size() < DEPTH || pop_now)) begin hit = 1; hd = req_di; end
                else for (int i = q.size() - 1; i >= 0; i--)
                    if (!hit && q[i].a == req_addr) begin hit = 1; hd = q[i].d; end
                if (hit) eq.push_back('{hd, 1'b1, cyc});
                else begin
                    eq.push_back('{mdl[req_addr], 1'b0, cyc});
                    read_out = 1; read_addr = req_addr;
                end
            end
            if (pop_now) begin
                mdl[q[0].a] = q[0].d;
                void'(q.pop_front());
                scnt = 0; wdone++;
            end
`ifdef EEP_MEM_DIRTY_EN
            dirty_exp = pop_now || (dirty_exp && !dirty_clr);
`endif
            if (req_we) begin
                if (q.size() < DEPTH) q.push_back('{req_addr, req_di});
                else ovf_exp = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask
    task automatic do_reset();
        rst = 1; steps(2); rst = 0;
        @(negedge clk);
        chk("rst_mem_ce", mem_ce, 0);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_strobes", {mem_oe, we_hi, we_lo}, 0);
    endtask
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        req_addr = a; req_di = d; req_we = 1; step(); req_we = 0;
    endtask
    int issue;
    task automatic rd(input logic [15:0] a);
        req_addr = a; req_oe = 1; issue = cyc; step(); req_oe = 0;
    endtask

    int s0, s1;
    logic exp_dirty;
    initial begin
        rst = 1; req_addr = '0; req_di = '0; req_we = 0; req_oe = 0; gnt = 0; dirty_clr = 0;
        do_reset();
        // Single write with immediate grant.
        gnt = 1; s0 = hi_cnt; s1 = busy_cnt;
        wr(16'h0010, 8'h5A); steps(10);
        chk("t1_we_hi_cycles", hi_cnt - s0, 3);
        chk("t1_addr", last_we_addr, 19'h00008);
        chk("t1_di", last_we_di, 16'h5A5A);
        chk("t1_busy_cycles", busy_cnt - s1, 0);
        // Overflow: fifth posted write dropped while grant withheld.
        do_reset();
        gnt = 0;
        for (int i = 0; i < 5; i++) wr(16'h0020 + 16'(i), 8'hC0 + 8'(i));
        @(negedge clk);
        chk("t2_ovf", ovf, 1);
        chk("t2_busy", busy, 1);
        s0 = wdone; gnt = 1; steps(40);
        chk("t2_writes", wdone - s0, 4);
        chk("t2_last_kept", env[16'h0023], 8'hC3);
        chk("t2_dropped", env[16'h0024], 8'h18);
        // Read forwarded from the FIFO without an SRAM access.
        do_reset();
        gnt = 0; s0 = oe_cnt;
        wr(16'h0003, 8'h11); rd(16'h0003); steps(5);
        chk("t3_latency", last_vld_cyc - issue, 1);
        chk("t3_data", last_rd_do, 8'h11);
        chk("t3_no_oe", oe_cnt - s0, 0);
        gnt = 1; steps(12);
        // Same-cycle write and read.
        gnt = 0;
        req_addr = 16'h0040; req_di = 8'h99; req_we = 1; req_oe = 1; issue = cyc; step();
        req_we = 0; req_oe = 0; steps(3);
        chk("t3b_latency", last_vld_cyc - issue, 1);
        chk("t3b_data", last_rd_do, 8'h99);
        gnt = 1; steps(12);
        // SRAM reads on both byte lanes.
        do_reset();
        gnt = 1;
        rd(16'h0005); steps(8);
        chk("t4_lo_data", last_rd_do, 8'hB2);
        chk("t4_lo_latency", last_vld_cyc - issue, 5);
        rd(16'h0004); steps(8);
        chk("t4_hi_data", last_rd_do, 8'hA1);
        chk("t4_hi_latency", last_vld_cyc - issue, 5);
        // Read arriving mid-drain.
        s0 = wdone;
        wr(16'h0050, 8'hD0); wr(16'h0051, 8'hD1); wr(16'h0052, 8'hD2);
        rd(16'h0006); steps(40);
        chk("t7_data", last_rd_do, 8'h3A);
        chk("t7_writes", wdone - s0, 3);
        // Reset during the second cycle of a write access.
        do_reset();
        gnt = 1;
        wr(16'h0030, 8'h77); wr(16'h0032, 8'h78); steps(2);
        rst = 1; step(); rst = 0;
        @(negedge clk);
        chk("t5_strobe_drop", {we_hi, we_lo}, 0);
        chk("t5_ce_drop", mem_ce, 0);
        s0 = we_cnt; steps(10);
        chk("t5_no_access", we_cnt - s0, 0);
        // Dirty flag: clear coinciding with a completion does not lose it.
        do_reset();
        gnt = 1;
        wr(16'h0060, 8'h42); steps(4);
        dirty_clr = 1; step(); dirty_clr = 0;
`ifdef EEP_MEM_DIRTY_EN
        exp_dirty = 1;
`else
        exp_dirty = 0;
`endif
        @(negedge clk);
        chk("t6_dirty_kept", dirty, exp_dirty);
        step(); dirty_clr = 1; step(); dirty_clr = 0;
        @(negedge clk);
        chk("t6_dirty_cleared", dirty, 0);
        steps(4);
        chk("end_queue_empty", q.size(), 0);
        chk("end_reads_done", eq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
